uart_rx_byte: RTL and testbench

- Asynchronous serial receiver (8N1) that sits directly upstream of the 8-bit UART data PIO.
- Its `rx_data` output drives the PIO `in_port`.
- Its status flags are intended for a companion status PIO, so software can poll for new bytes and errors.
- Oversamples the line on the 50 MHz system clock and samples each bit at mid-bit.

---
 rtl/uart_rx_byte_if.sv | 21 ++
 rtl/uart_rx_byte.sv | 122 ++++++++++++
 tb/tb_uart_rx_byte.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: raw serial line and clear strobe in, received byte and sticky status out.
interface uart_rx_byte_if;
  logic       rx_serial;
  logic       rx_clear;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_flag;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  modport master (
    input  rx_serial, rx_clear,
    output rx_data, rx_valid, rx_flag, frame_error, overrun, busy
  );

  modport slave (
    output rx_serial, rx_clear,
    input  rx_data, rx_valid, rx_flag, frame_error, overrun, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, mid-bit sampling; rx_valid 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after the start edge.
// No backpressure: an unread byte is overwritten and flagged through the sticky overrun bit.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_byte_if.master bus
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             sync1;
  logic             rxs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_flag_q;
  logic             frame_error_q;
  logic             overrun_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= bus.rx_serial;
      rxs   <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_flag_q     <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // Clear is applied first so that a set in the same cycle wins.
      if (bus.rx_clear) begin
        rx_flag_q     <= 1'b0;
        frame_error_q <= 1'b0;
        overrun_q     <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_M1) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            state <= IDLE;
            if (rxs) begin
              rx_data_q  <= shreg;
              rx_valid_q <= 1'b1;
              rx_flag_q  <= 1'b1;
              if (rx_flag_q && !bus.rx_clear) overrun_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_flag     = rx_flag_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;

  uart_rx_byte_if bus();

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         vld_cnt = 0;
  logic       was_vld = 1'b0;
  logic [7:0] exp_q[$];
  int         fall_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rx_valid pulse is matched against the next expected byte.
  always @(negedge clk) begin
    int d;
    if (was_vld) check("rx_valid_one_cycle", {31'd0, bus.rx_valid}, 32'd0);
    was_vld = bus.rx_valid && !reset;
    if (!reset && bus.rx_valid) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rx_valid: rx_data %0h with no byte expected (t=%0t)", bus.rx_data, $time);
      end else begin
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        check("rx_flag_at_valid", {31'd0, bus.rx_flag}, 32'd1);
        d = cyc - fall_q.pop_front();
        if (d < 154 || d > 156) begin
          n_cmp++;
          n_bad++;
          $display("FAIL latency: got %0d clocks, expected 154..156", d);
        end else begin
          n_cmp++;
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // clear_at: stop-bit clock index at which rx_clear is pulsed (-1 for none).
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int clear_at);
    if (stop_bit) begin
      exp_q.push_back(d);
      fall_q.push_back(cyc);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    bus.rx_serial = stop_bit;
    for (int j = 0; j < CPB; j++) begin
      bus.rx_clear = (j == clear_at);
      @(negedge clk);
    end
    bus.rx_clear = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.rx_clear = 1'b1;
    @(negedge clk);
    bus.rx_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic [7:0] data, input logic flag,
                              input logic fe, input logic ov, input int nvld);
    check({tag, "_rx_data"},     {24'd0, bus.rx_data},     {24'd0, data});
    check({tag, "_rx_flag"},     {31'd0, bus.rx_flag},     {31'd0, flag});
    check({tag, "_frame_error"}, {31'd0, bus.frame_error}, {31'd0, fe});
    check({tag, "_overrun"},     {31'd0, bus.overrun},     {31'd0, ov});
    check({tag, "_busy"},        {31'd0, bus.busy},        32'd0);
    check({tag, "_vld_count"},   vld_cnt,                  nvld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.rx_serial = 1'b1;
    bus.rx_clear  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    idle(5);

    // Single good byte
    send_byte(8'hA5, 1'b1, -1);
    idle(20);
    check_status("t1", 8'hA5, 1'b1, 1'b0, 1'b0, 1);
    pulse_clear();
    check("t1_clear_flag", {31'd0, bus.rx_flag}, 32'd0);

    // Short low glitch is rejected at the half-bit re-check
    bus.rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_busy_in_glitch", {31'd0, bus.busy}, 32'd1);
    idle(20);
    check_status("t2", 8'hA5, 1'b0, 1'b0, 1'b0, 1);

    // Framing error keeps the previous byte
    send_byte(8'h3C, 1'b0, -1);
    idle(30);
    check_status("t3", 8'hA5, 1'b0, 1'b1, 1'b0, 1);
    pulse_clear();
    check("t3_clear_fe", {31'd0, bus.frame_error}, 32'd0);

    // Back-to-back bytes without clear produce overrun
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    idle(20);
    check_status("t4", 8'h22, 1'b1, 1'b0, 1'b1, 3);

    // Clear coincides with byte completion: set wins, overrun not set
    send_byte(8'h7E, 1'b1, 10);
    idle(20);
    check_status("t5", 8'h7E, 1'b1, 1'b0, 1'b0, 4);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0);
    bus.rx_serial = 1'b1;
    repeat (4 * CPB + 8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check_status("t6_rst", 8'h00, 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b0;
    idle(20);
    send_byte(8'h5A, 1'b1, -1);
    idle(20);
    check_status("t6", 8'h5A, 1'b1, 1'b0, 1'b0, 5);
    check("expected_queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
